// File: rtl/debug_run_ctrl.sv
// rtl/debug_run_ctrl.sv - run/halt/step/dump sequencer for the RV32 core debug port (optional watchdog: DRC_WATCHDOG_EN)
module debug_run_ctrl #(
   parameter bit START_RUN = 1'b1,
   parameter int DBG_LAT   = 2,
   parameter int STEP_GAP  = 1,
   parameter int DUMP_LEN  = 64,
   parameter int WDOG_W    = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_arg,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   input  logic [31:0] debug_wb_PC,
   input  logic [31:0] debug_data,
   output logic        debug_en,
   output logic        debug_step,
   output logic [6:0]  debug_addr,
   output logic        dump_valid,
   input  logic        dump_ready,
   output logic [6:0]  dump_addr,
   output logic [31:0] dump_data,
   output logic        halted,
`ifdef DRC_WATCHDOG_EN
   output logic        wdog_hit,
`endif
   output logic        bp_hit
);

   typedef enum logic [2:0] {
      S_HALT, S_RUN, S_STEP_P, S_STEP_G, S_DUMP_A, S_DUMP_W, S_DUMP_O
   } state_t;

   localparam logic [1:0] OP_HALT = 2'd0;
   localparam logic [1:0] OP_RUN  = 2'd1;
   localparam logic [1:0] OP_STEP = 2'd2;
   localparam logic [1:0] OP_DUMP = 2'd3;

   localparam state_t RST_STATE = START_RUN ? S_RUN : S_HALT;
   localparam int WAIT_W = $clog2(DBG_LAT + 1);
   localparam int GAP_W  = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DBG_LAT);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((STEP_GAP > 0) ? STEP_GAP - 1 : 0);
   localparam logic [6:0]        LAST_ADDR = 7'(DUMP_LEN - 1);

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [6:0]        addr_q, addr_d;
   logic [6:0]        debug_addr_q, debug_addr_d;
   logic              dump_valid_q, dump_valid_d;
   logic [6:0]        dump_addr_q, dump_addr_d;
   logic [31:0]       dump_data_q, dump_data_d;
   logic              bp_hit_q, bp_hit_d;
   logic              chk_q, chk_d;
   logic              bp_match_q;
   logic              debug_en_q, halted_q;
   logic              bp_now, cmd_acc;

`ifdef DRC_WATCHDOG_EN
   logic [WDOG_W-1:0] wdog_q;
   logic [31:0]       pc_prev_q;
   logic              wdog_hit_q, wdog_hit_d;
`endif

   // chk_q marks the post-pulse breakpoint check cycle when there is no gap state
   assign bp_now     = bp_en && (debug_wb_PC == bp_addr);
   assign cmd_ready  = ((state_q == S_HALT) || (state_q == S_RUN)) && !chk_q;
   assign cmd_acc    = cmd_valid && cmd_ready;
   assign debug_step = (state_q == S_STEP_P) && !(chk_q && bp_now);
   assign debug_en   = debug_en_q;
   assign debug_addr = debug_addr_q;
   assign dump_valid = dump_valid_q;
   assign dump_addr  = dump_addr_q;
   assign dump_data  = dump_data_q;
   assign halted     = halted_q;
   assign bp_hit     = bp_hit_q;

   // Next-state and datapath updates for the sequencer
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gap_d        = gap_q;
      wait_d       = wait_q;
      addr_d       = addr_q;
      debug_addr_d = debug_addr_q;
      dump_valid_d = dump_valid_q;
      dump_addr_d  = dump_addr_q;
      dump_data_d  = dump_data_q;
      bp_hit_d     = bp_hit_q;
      chk_d        = 1'b0;
`ifdef DRC_WATCHDOG_EN
      wdog_hit_d   = wdog_hit_q;
      if (cmd_acc && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP))) wdog_hit_d = 1'b0;
`endif
      case (state_q)
         S_HALT: begin
            if (cmd_acc) begin
               case (cmd_op)
                  OP_RUN: begin
                     state_d  = S_RUN;
                     bp_hit_d = 1'b0;
                  end
                  OP_STEP: begin
                     cnt_d    = (cmd_arg == 16'd0) ? 16'd1 : cmd_arg;
                     bp_hit_d = 1'b0;
                     state_d  = S_STEP_P;
                  end
                  OP_DUMP: begin
                     addr_d  = 7'd0;
                     state_d = S_DUMP_A;
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (cmd_acc && (cmd_op == OP_RUN)) bp_hit_d = 1'b0;
            if (cmd_acc && (cmd_op == OP_HALT)) state_d = S_HALT;
            if (bp_match_q) begin
               state_d  = S_HALT;
               bp_hit_d = 1'b1;
            end
         end
         S_STEP_P: begin
            if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
            gap_d = '0;
            if (STEP_GAP == 0) begin
               chk_d   = 1'b1;
               state_d = (cnt_q <= 16'd1) ? S_HALT : S_STEP_P;
            end else begin
               state_d = S_STEP_G;
            end
         end
         S_STEP_G: begin
            if (gap_q == GAP_LAST) begin
               if (bp_now) begin
                  state_d  = S_HALT;
                  bp_hit_d = 1'b1;
                  cnt_d    = 16'd0;
               end else begin
                  state_d = (cnt_q != 16'd0) ? S_STEP_P : S_HALT;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_DUMP_A: begin
            debug_addr_d = addr_q;
            wait_d       = '0;
            state_d      = S_DUMP_W;
         end
         S_DUMP_W: begin
            if (wait_q == WAIT_LAST) begin
               dump_data_d  = debug_data;
               dump_addr_d  = addr_q;
               dump_valid_d = 1'b1;
               state_d      = S_DUMP_O;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DUMP_O: begin
            if (dump_ready) begin
               dump_valid_d = 1'b0;
               if (addr_q == LAST_ADDR) begin
                  state_d = S_HALT;
               end else begin
                  addr_d  = addr_q + 7'd1;
                  state_d = S_DUMP_A;
               end
            end
         end
         default: state_d = S_HALT;
      endcase
      if ((STEP_GAP == 0) && chk_q && bp_now) begin
         state_d  = S_HALT;
         bp_hit_d = 1'b1;
         cnt_d    = 16'd0;
      end
`ifdef DRC_WATCHDOG_EN
      if ((state_q == S_RUN) && (&wdog_q)) begin
         state_d    = S_HALT;
         wdog_hit_d = 1'b1;
      end
`endif
   end

   // State and output registers; debug_en/halted follow the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= RST_STATE;
         cnt_q        <= 16'd0;
         gap_q        <= '0;
         wait_q       <= '0;
         addr_q       <= 7'd0;
         debug_addr_q <= 7'd0;
         dump_valid_q <= 1'b0;
         dump_addr_q  <= 7'd0;
         dump_data_q  <= 32'd0;
         bp_hit_q     <= 1'b0;
         chk_q        <= 1'b0;
         bp_match_q   <= 1'b0;
         debug_en_q   <= !START_RUN;
         halted_q     <= !START_RUN;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         wait_q       <= wait_d;
         addr_q       <= addr_d;
         debug_addr_q <= debug_addr_d;
         dump_valid_q <= dump_valid_d;
         dump_addr_q  <= dump_addr_d;
         dump_data_q  <= dump_data_d;
         bp_hit_q     <= bp_hit_d;
         chk_q        <= chk_d;
         bp_match_q   <= bp_now;
         debug_en_q   <= (state_d != S_RUN);
         halted_q     <= (state_d == S_HALT);
      end
   end

`ifdef DRC_WATCHDOG_EN
   // Watchdog: count RUN cycles during which the WB PC has not moved
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_q     <= '0;
         pc_prev_q  <= 32'd0;
         wdog_hit_q <= 1'b0;
      end else begin
         pc_prev_q  <= debug_wb_PC;
         wdog_hit_q <= wdog_hit_d;
         if ((state_q == S_RUN) && (debug_wb_PC == pc_prev_q)) wdog_q <= wdog_q + 1'b1;
         else wdog_q <= '0;
      end
   end

   assign wdog_hit = wdog_hit_q;
`endif

endmodule

// File: tb/tb_debug_run_ctrl.sv
// tb/tb_debug_run_ctrl.sv - testbench for debug_run_ctrl
module tb_debug_run_ctrl;
   localparam int DUMP_LEN = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [15:0] cmd_arg = 16'd0;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = 32'd0;
   logic [31:0] debug_wb_PC;
   logic [31:0] debug_data;
   logic        debug_en, debug_step;
   logic [6:0]  debug_addr;
   logic        dump_valid;
   logic        dump_ready = 1'b0;
   logic [6:0]  dump_addr;
   logic [31:0] dump_data;
   logic        halted, bp_hit;

   int checks = 0;
   int errors = 0;

   logic [31:0] pc;
   logic [6:0]  d1, d2;
   logic [38:0] sb_q[$];

   debug_run_ctrl #(
      .START_RUN(1'b0), .DBG_LAT(2), .STEP_GAP(1), .DUMP_LEN(DUMP_LEN), .WDOG_W(24)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .bp_en(bp_en), .bp_addr(bp_addr),
      .debug_wb_PC(debug_wb_PC), .debug_data(debug_data), .debug_en(debug_en),
      .debug_step(debug_step), .debug_addr(debug_addr), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
      .halted(halted), .bp_hit(bp_hit)
   );

   always #5 clk = ~clk;

   // Core model: PC advances when running or stepped; debug read has 2-cycle latency
   assign debug_wb_PC = pc;
   assign debug_data  = 32'hDA7A_0000 | {25'd0, d2};
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= 32'd0;
         d1 <= 7'd0;
         d2 <= 7'd0;
      end else begin
         if (!debug_en || debug_step) pc <= pc + 32'd4;
         d1 <= debug_addr;
         d2 <= d1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] arg);
      cmd_op    = op;
      cmd_arg   = arg;
      cmd_valid = 1'b1;
      check("cmd_ready_on_issue", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic step_trace(input bit probe, output logic [11:0] m);
      m = '0;
      for (int i = 0; i < 12; i++) begin
         m[i] = debug_step;
         if (probe && i == 0) begin
            cmd_op    = 2'd3;
            cmd_valid = 1'b1;
            check("cmd_ready_in_step_p", {31'd0, cmd_ready}, 32'd0);
         end
         tick();
         cmd_valid = 1'b0;
      end
   endtask

   initial begin
      logic [11:0] m;
      logic [38:0] exp;
      logic [31:0] held;
      int t_pc, t_en, cyc, stall;
      logic en_ok;

      held = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tick();
      check("rst_debug_en",   {31'd0, debug_en},   32'd1);
      check("rst_halted",     {31'd0, halted},     32'd1);
      check("rst_cmd_ready",  {31'd0, cmd_ready},  32'd1);
      check("rst_debug_step", {31'd0, debug_step}, 32'd0);
      check("rst_debug_addr", {25'd0, debug_addr}, 32'd0);
      check("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
      check("rst_dump_addr",  {25'd0, dump_addr},  32'd0);
      check("rst_dump_data",  dump_data,           32'd0);
      check("rst_bp_hit",     {31'd0, bp_hit},     32'd0);

      // RUN until the core reaches the breakpoint PC
      bp_en   = 1'b1;
      bp_addr = 32'h0000_0010;
      issue(2'd1, 16'd0);
      check("run_debug_en", {31'd0, debug_en}, 32'd0);
      check("run_halted",   {31'd0, halted},   32'd0);
      t_pc = -1;
      t_en = -1;
      for (int i = 1; i <= 20 && t_en < 0; i++) begin
         tick();
         if (pc == 32'h10 && t_pc < 0) t_pc = i;
         if (debug_en && t_en < 0) t_en = i;
      end
      check("bp_halt_latency", {31'd0, (t_pc >= 0 && t_en > t_pc && (t_en - t_pc) <= 2)}, 32'd1);
      check("bp_hit_set",   {31'd0, bp_hit}, 32'd1);
      check("bp_halted",    {31'd0, halted}, 32'd1);
      bp_en = 1'b0;
      issue(2'd1, 16'd0);
      check("bp_hit_cleared", {31'd0, bp_hit}, 32'd0);
      check("rerun_halted",   {31'd0, halted}, 32'd0);
      tick();
      issue(2'd0, 16'd0);
      check("halt_cmd_halted",   {31'd0, halted},   32'd1);
      check("halt_cmd_debug_en", {31'd0, debug_en}, 32'd1);

      // STEP 3 with a rejected command during STEP_P, then STEP 0
      issue(2'd2, 16'd3);
      step_trace(1'b1, m);
      check("step3_pulses", {20'd0, m}, 32'h015);
      check("step3_halted", {31'd0, halted}, 32'd1);
      issue(2'd2, 16'd0);
      step_trace(1'b0, m);
      check("step0_pulses", {20'd0, m}, 32'h001);
      check("step0_halted", {31'd0, halted}, 32'd1);

      // STEP 5 with a breakpoint two instructions ahead
      bp_en   = 1'b1;
      bp_addr = pc + 32'd8;
      issue(2'd2, 16'd5);
      step_trace(1'b0, m);
      check("step_bp_pulses", {20'd0, m}, 32'h005);
      check("step_bp_hit",    {31'd0, bp_hit}, 32'd1);
      check("step_bp_halted", {31'd0, halted}, 32'd1);
      bp_en = 1'b0;

      // DUMP with a 3-cycle consumer stall on word 1
      for (int a = 0; a < DUMP_LEN; a++) sb_q.push_back({a[6:0], 32'hDA7A_0000 | 32'(a)});
      issue(2'd3, 16'd0);
      cyc   = 0;
      stall = 0;
      en_ok = 1'b1;
      while (sb_q.size() > 0 && cyc < 200) begin
         cyc++;
         en_ok = en_ok & debug_en;
         if (cyc == 2) begin
            cmd_op    = 2'd1;
            cmd_valid = 1'b1;
            check("cmd_ready_in_dump_w", {31'd0, cmd_ready}, 32'd0);
         end
         if (dump_valid) begin
            if (dump_addr == 7'd1 && stall < 3) begin
               if (stall == 0) held = dump_data;
               else check("dump_hold", dump_data, held);
               stall++;
               dump_ready = 1'b0;
            end else begin
               exp = sb_q.pop_front();
               check("dump_addr", {25'd0, dump_addr}, {25'd0, exp[38:32]});
               check("dump_data", dump_data, exp[31:0]);
               dump_ready = 1'b1;
            end
         end
         tick();
         dump_ready = 1'b0;
         cmd_valid  = 1'b0;
      end
      check("dump_all_words", sb_q.size(), 32'd0);
      tick();
      check("dump_end_halted", {31'd0, halted},     32'd1);
      check("dump_end_valid",  {31'd0, dump_valid}, 32'd0);
      check("dump_debug_en",   {31'd0, en_ok},      32'd1);

      // Asynchronous reset while a dump word is waiting
      issue(2'd3, 16'd0);
      cyc = 0;
      while (!dump_valid && cyc < 50) begin
         tick();
         cyc++;
      end
      check("dump_o_reached", {31'd0, dump_valid}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("arst_dump_valid", {31'd0, dump_valid}, 32'd0);
      check("arst_dump_data",  dump_data,           32'd0);
      check("arst_debug_step", {31'd0, debug_step}, 32'd0);
      check("arst_halted",     {31'd0, halted},     32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      check("post_rst_halted",    {31'd0, halted},    32'd1);
      check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("post_rst_debug_en",  {31'd0, debug_en},  32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
